// File: rtl/skid_reg.sv
// Two-entry valid/ready pipeline register: main entry drives the output, skid entry absorbs one stalled beat.
// Latency: one cycle in to out, full throughput. Backpressure: in_ready comes from registered state only.
// Optional synchronous pipeline flush is compiled in with `define SKID_REG_FLUSH_EN.
module skid_reg #(
  parameter int unsigned           WIDTH     = 32,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef SKID_REG_FLUSH_EN
  input  logic             flush,
`endif
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  logic             main_v, skid_v;
  logic [WIDTH-1:0] main_data, skid_data;
  logic             main_v_n, skid_v_n;
  logic [WIDTH-1:0] main_data_n, skid_data_n;
  logic             acc_in, acc_out;
  state_t           state;

`ifdef SKID_REG_FLUSH_EN
  assign in_ready = !skid_v && !clr && !flush;
`else
  assign in_ready = !skid_v && !clr;
`endif
  assign out_valid = main_v;
  assign out_data  = main_data;
  assign count     = 2'(main_v) + 2'(skid_v);
  assign acc_in    = in_valid && in_ready;
  assign acc_out   = main_v && out_ready;

  // The state is just a view of the two valid bits (skid_v implies main_v).
  always_comb begin
    state = EMPTY;
    if (skid_v)      state = FULL;
    else if (main_v) state = ONE;
  end

  always_comb begin
    main_v_n    = main_v;
    skid_v_n    = skid_v;
    main_data_n = main_data;
    skid_data_n = skid_data;
    case (state)
      EMPTY: begin
        if (acc_in) begin
          main_data_n = in_data;
          main_v_n    = 1'b1;
        end
      end
      ONE: begin
        if (acc_in && acc_out) begin
          main_data_n = in_data;
        end else if (acc_in) begin
          skid_data_n = in_data;
          skid_v_n    = 1'b1;
        end else if (acc_out) begin
          main_v_n = 1'b0;
        end
      end
      FULL: begin
        if (acc_out) begin
          main_data_n = skid_data;
          skid_v_n    = 1'b0;
        end
      end
      default: ;
    endcase
`ifdef SKID_REG_FLUSH_EN
    // A same-edge delivery still counts, but nothing is reloaded.
    if (flush) begin
      main_v_n    = 1'b0;
      skid_v_n    = 1'b0;
      main_data_n = main_data;
      skid_data_n = skid_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_data <= RESET_VAL;
      skid_data <= RESET_VAL;
    end else begin
      main_v    <= main_v_n;
      skid_v    <= skid_v_n;
      main_data <= main_data_n;
      skid_data <= skid_data_n;
    end
  end

endmodule
